// File: rtl/key_pkg.sv
// Shared constants for the key single-step path: FSM state encoding and step counter width.
package key_pkg;

   localparam int STEP_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_RUN    = 2'd3
   } state_e;

endpackage

// File: rtl/step_stretch.sv
// Stretches each one-cycle step strobe into a STEP_WIDTH-cycle high pulse on cpu_clk.
module step_stretch #(
   parameter int STEP_WIDTH = 4
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic step_pulse,
   output logic cpu_clk
);

   localparam int W = (STEP_WIDTH > 1) ? $clog2(STEP_WIDTH) : 1;

   logic [W-1:0] width_q;
   logic [W-1:0] width_d;

   always_comb begin
      width_d = width_q;
      if (step_pulse) begin
         width_d = W'(STEP_WIDTH - 1);
      end else if (width_q != '0) begin
         width_d = width_q - W'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         width_q <= '0;
      end else begin
         width_q <= width_d;
      end
   end

   // NOTE: cpu_clk is an OR of the strobe and the remaining width, so it rises in the
   // strobe cycle and a restart while high can never produce a low glitch.
   assign cpu_clk = step_pulse | (width_q != '0);

endmodule

// File: rtl/key_step_ctrl.sv
// Single-step controller: turns debounced key presses into CPU step events with
// hold-to-repeat, a free-running mode, a stretched cpu_clk and a wrapping step counter.
module key_step_ctrl
   import key_pkg::*;
#(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int RUN_DIV       = 25_000_000,
   parameter int STEP_WIDTH    = 4,
   parameter int CNT_W         = 32
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  key_n,
   input  logic                  repeat_en,
   input  logic                  run_en,
   input  logic                  clr_cnt,
   output logic                  step_pulse,
   output logic                  cpu_clk,
   output logic [STEP_CNT_W-1:0] step_cnt,
   output logic [1:0]            state_o
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_DIV - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        ivl_q, ivl_d;
   logic                    key_prev_q, key_prev_d;
   logic                    step_pulse_q, step_pulse_d;
   logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;
   logic                    press;

   assign press = key_prev_q & ~key_n;

   always_comb begin
      state_d      = state_q;
      ivl_d        = ivl_q;
      step_pulse_d = 1'b0;
      key_prev_d   = key_n;

      case (state_q)
         ST_IDLE: begin
            ivl_d = '0;
            if (run_en) begin
               state_d = ST_RUN;
            end else if (press) begin
               step_pulse_d = 1'b1;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (run_en) begin
               state_d = ST_RUN;
               ivl_d   = '0;
            end else if (key_n) begin
               state_d = ST_IDLE;
               ivl_d   = '0;
            end else if (repeat_en) begin
               // A counter frozen by an earlier REPEAT exit may already sit past the hold mark.
               if (ivl_q >= HOLD_LAST) begin
                  step_pulse_d = 1'b1;
                  ivl_d        = '0;
                  state_d      = ST_REPEAT;
               end else begin
                  ivl_d = ivl_q + CNT_W'(1);
               end
            end
         end
         ST_REPEAT: begin
            if (run_en) begin
               state_d = ST_RUN;
               ivl_d   = '0;
            end else if (key_n) begin
               state_d = ST_IDLE;
               ivl_d   = '0;
            end else if (!repeat_en) begin
               state_d = ST_HOLD;
            end else if (ivl_q == REPEAT_LAST) begin
               step_pulse_d = 1'b1;
               ivl_d        = '0;
            end else begin
               ivl_d = ivl_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!run_en) begin
               state_d = ST_IDLE;
               ivl_d   = '0;
            end else if (ivl_q == RUN_LAST) begin
               step_pulse_d = 1'b1;
               ivl_d        = '0;
            end else begin
               ivl_d = ivl_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            ivl_d   = '0;
         end
      endcase

      // The counter tracks the strobe edge, so a clear sampled together with a step wins.
      step_cnt_d = step_cnt_q;
      if (clr_cnt) begin
         step_cnt_d = '0;
      end else if (step_pulse_d) begin
         step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
      end
   end

   // NOTE: all state updates use non-blocking assignments; key_prev resets high so a key
   // already held when reset releases is seen as one fresh press.
   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         ivl_q        <= '0;
         key_prev_q   <= 1'b1;
         step_pulse_q <= 1'b0;
         step_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         ivl_q        <= ivl_d;
         key_prev_q   <= key_prev_d;
         step_pulse_q <= step_pulse_d;
         step_cnt_q   <= step_cnt_d;
      end
   end

   step_stretch #(
      .STEP_WIDTH (STEP_WIDTH)
   ) u_stretch (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .step_pulse (step_pulse_q),
      .cpu_clk    (cpu_clk)
   );

   assign step_pulse = step_pulse_q;
   assign step_cnt   = step_cnt_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Self-checking bench for key_step_ctrl: vector table, directed multi-cycle sequences,
// and a randomized phase compared against a behavioural model of the step rules.
module tb_key_step_ctrl;
   import key_pkg::*;

   localparam int HOLD_CYCLES   = 20;
   localparam int REPEAT_CYCLES = 8;
   localparam int RUN_DIV       = 5;
   localparam int STEP_WIDTH    = 2;

   logic                  clk_sys = 1'b0;
   logic                  reset   = 1'b0;
   logic                  key_n   = 1'b1;
   logic                  repeat_en = 1'b0;
   logic                  run_en  = 1'b0;
   logic                  clr_cnt = 1'b0;
   logic                  step_pulse;
   logic                  cpu_clk;
   logic [STEP_CNT_W-1:0] step_cnt;
   logic [1:0]            state_o;

   key_step_ctrl #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .RUN_DIV       (RUN_DIV),
      .STEP_WIDTH    (STEP_WIDTH),
      .CNT_W         (32)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .key_n      (key_n),
      .repeat_en  (repeat_en),
      .run_en     (run_en),
      .clr_cnt    (clr_cnt),
      .step_pulse (step_pulse),
      .cpu_clk    (cpu_clk),
      .step_cnt   (step_cnt),
      .state_o    (state_o)
   );

   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases use the published encoding: 0 idle, 1 hold, 2 repeat, 3 run.
   int m_phase, m_wait, m_steps, m_cycle, m_last_step;
   bit m_prev_key, m_pulse;

   function automatic void model_reset();
      m_phase     = 0;
      m_wait      = 0;
      m_steps     = 0;
      m_cycle     = 0;
      m_last_step = -100;
      m_prev_key  = 1'b1;
      m_pulse     = 1'b0;
   endfunction

   function automatic void model_step();
      bit issue;
      bit press;
      issue = 1'b0;
      press = m_prev_key && !key_n;
      m_cycle++;
      if (m_phase != 3 && run_en) begin
         m_phase = 3;
         m_wait  = 0;
      end else if (m_phase == 3) begin
         if (!run_en) begin
            m_phase = 0;
            m_wait  = 0;
         end else if (m_wait == RUN_DIV - 1) begin
            issue  = 1'b1;
            m_wait = 0;
         end else begin
            m_wait++;
         end
      end else if (m_phase == 0) begin
         if (press) begin
            issue   = 1'b1;
            m_phase = 1;
            m_wait  = 0;
         end
      end else if (key_n) begin
         m_phase = 0;
         m_wait  = 0;
      end else if (m_phase == 1) begin
         if (repeat_en) begin
            if (m_wait == HOLD_CYCLES - 1) begin
               issue   = 1'b1;
               m_phase = 2;
               m_wait  = 0;
            end else begin
               m_wait++;
            end
         end
      end else begin
         if (!repeat_en) begin
            m_phase = 1;
         end else if (m_wait == REPEAT_CYCLES - 1) begin
            issue  = 1'b1;
            m_wait = 0;
         end else begin
            m_wait++;
         end
      end
      m_prev_key = key_n;
      m_pulse    = issue;
      if (issue) m_last_step = m_cycle;
      if (clr_cnt) m_steps = 0;
      else if (issue) m_steps = (m_steps + 1) % 65536;
   endfunction

   task automatic tick();
      if (reset) model_step();
      else model_reset();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic compare_model(input string tag);
      check({tag, "_pulse"}, int'(step_pulse), int'(m_pulse));
      check({tag, "_cpu_clk"}, int'(cpu_clk), int'((m_cycle - m_last_step) < STEP_WIDTH));
      check({tag, "_cnt"}, int'(step_cnt), m_steps);
      check({tag, "_state"}, int'(state_o), m_phase);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit key_n;
      bit repeat_en;
      bit run_en;
      bit clr_cnt;
      bit pulse;
      bit cpu;
      int cnt;
      int st;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int k, input int r, input int u, input int c,
                      input int p, input int cc, input int n, input int s);
      vec_t v;
      v.key_n = (k != 0); v.repeat_en = (r != 0); v.run_en = (u != 0); v.clr_cnt = (c != 0);
      v.pulse = (p != 0); v.cpu = (cc != 0); v.cnt = n; v.st = s;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pulses[$];
      int vals[$];
      int exp_rep[5];
      int n;
      int seg;

      exp_rep = '{1, 21, 29, 37, 45};
      model_reset();

      // Single press (key low 10 cycles), then press+run in the same cycle,
      // run exit with the key held, a fresh press, and a clear.
      //  key rep run clr | pulse cpu cnt st
      add(1, 0, 0, 0,  0, 0, 0, 0);
      add(0, 0, 0, 0,  1, 1, 1, 1);
      add(0, 0, 0, 0,  0, 1, 1, 1);
      for (int i = 0; i < 8; i++) add(0, 0, 0, 0,  0, 0, 1, 1);
      add(1, 0, 0, 0,  0, 0, 1, 0);
      add(1, 0, 0, 0,  0, 0, 1, 0);
      add(0, 0, 1, 0,  0, 0, 1, 3);
      for (int i = 0; i < 4; i++) add(0, 0, 1, 0,  0, 0, 1, 3);
      add(0, 0, 1, 0,  1, 1, 2, 3);
      add(0, 0, 0, 0,  0, 1, 2, 0);
      add(0, 0, 0, 0,  0, 0, 2, 0);
      add(1, 0, 0, 0,  0, 0, 2, 0);
      add(0, 0, 0, 0,  1, 1, 3, 1);
      add(1, 0, 0, 0,  0, 1, 3, 0);
      add(1, 0, 0, 1,  0, 0, 0, 0);

      // Reset state
      repeat (3) tick();
      check("rst_pulse", int'(step_pulse), 0);
      check("rst_cpu_clk", int'(cpu_clk), 0);
      check("rst_cnt", int'(step_cnt), 0);
      check("rst_state", int'(state_o), 0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         key_n = vecs[i].key_n; repeat_en = vecs[i].repeat_en;
         run_en = vecs[i].run_en; clr_cnt = vecs[i].clr_cnt;
         tick();
         check($sformatf("vec%0d_pulse", i), int'(step_pulse), int'(vecs[i].pulse));
         check($sformatf("vec%0d_cpu_clk", i), int'(cpu_clk), int'(vecs[i].cpu));
         check($sformatf("vec%0d_cnt", i), int'(step_cnt), vecs[i].cnt);
         check($sformatf("vec%0d_state", i), int'(state_o), vecs[i].st);
      end
      clr_cnt = 1'b0;

      // Hold with auto-repeat: key low 50 cycles
      repeat_en = 1'b1;
      pulses.delete();
      for (int i = 0; i < 50; i++) begin
         key_n = 1'b0;
         tick();
         if (step_pulse) pulses.push_back(i + 1);
      end
      key_n = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (step_pulse) n++;
      end
      check("hold_n_steps", pulses.size(), 5);
      foreach (pulses[k]) if (k < 5) check($sformatf("hold_step%0d_at", k), pulses[k], exp_rep[k]);
      check("hold_after_release", n, 0);
      check("hold_cnt", int'(step_cnt), 5);
      check("hold_state", int'(state_o), 0);
      repeat_en = 1'b0;

      // Run mode for 26 cycles with the key held, then exit with the key still held
      pulses.delete();
      key_n  = 1'b0;
      run_en = 1'b1;
      for (int i = 0; i < 26; i++) begin
         tick();
         if (step_pulse) pulses.push_back(i + 1);
      end
      check("run_n_steps", pulses.size(), 5);
      if (pulses.size() > 0) check("run_first_at", pulses[0], 6);
      for (int k = 1; k < pulses.size(); k++) check("run_spacing", pulses[k] - pulses[k-1], 5);
      run_en = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (step_pulse) n++;
      end
      check("run_exit_held_steps", n, 0);
      check("run_exit_state", int'(state_o), 0);
      key_n = 1'b1;
      tick();
      key_n = 1'b0;
      tick();
      check("repress_pulse", int'(step_pulse), 1);
      check("repress_cnt", int'(step_cnt), 11);
      key_n = 1'b1;
      tick();

      // Counter wrap: preload near the top while idle, then step through 0xFFFF -> 0
      force dut.step_cnt_q = 16'hFFFE;
      tick();
      release dut.step_cnt_q;
      m_steps = 16'hFFFE;
      check("preload_cnt", int'(step_cnt), 65534);
      vals.delete();
      run_en = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick();
         if (step_pulse) vals.push_back(int'(step_cnt));
      end
      check("wrap_n_steps", vals.size(), 2);
      if (vals.size() == 2) begin
         check("wrap_ffff", vals[0], 65535);
         check("wrap_zero", vals[1], 0);
      end
      // Clear sampled in the same cycle as a step
      repeat (4) tick();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("clr_step_pulse", int'(step_pulse), 1);
      check("clr_step_cnt", int'(step_cnt), 0);
      repeat (5) tick();
      check("clr_then_step_cnt", int'(step_cnt), 1);
      run_en = 1'b0;
      tick();

      // Asynchronous reset in the middle of auto-repeat
      repeat_en = 1'b1;
      key_n     = 1'b0;
      repeat (29) tick();
      check("pre_reset_pulse", int'(step_pulse), 1);
      check("pre_reset_state", int'(state_o), 2);
      #2;
      reset = 1'b0;
      key_n = 1'b1;
      #1;
      check("async_rst_pulse", int'(step_pulse), 0);
      check("async_rst_cpu_clk", int'(cpu_clk), 0);
      check("async_rst_cnt", int'(step_cnt), 0);
      check("async_rst_state", int'(state_o), 0);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("post_rst_pulse", int'(step_pulse), 0);
      check("post_rst_state", int'(state_o), 0);
      repeat_en = 1'b0;

      // Key already held at reset release counts as exactly one press
      reset = 1'b0;
      key_n = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("held_rel_first_pulse", int'(step_pulse), 1);
      n = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (step_pulse) n++;
      end
      check("held_rel_steps", n, 1);
      key_n = 1'b1;
      tick();

      // Randomized phase against the model
      seg = 1;
      for (int i = 0; i < 3000; i++) begin
         seg--;
         if (seg == 0) begin
            key_n = ~key_n;
            seg   = int'($urandom_range(1, 40));
         end
         if ($urandom_range(0, 29) == 0) repeat_en = ~repeat_en;
         if ($urandom_range(0, 79) == 0) run_en = ~run_en;
         clr_cnt = ($urandom_range(0, 49) == 0);
         tick();
         compare_model("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
